// File: rtl/concat_requant_pkg.sv
// -----------------------------------------------------------------------------
// concat_requant_pkg
// Shared definitions for the concat requantiser:
//   - `PICTURE_NUM : number of pictures packed side by side in one beat
//                    (lane count = PICTURE_NUM * channels per picture)
//   - state_t      : control FSM state encoding (IDLE / RUN / DRAIN)
//   - round_bias   : round-half-up bias added before the arithmetic shift
//   - clamp_u8     : saturate a signed 64-bit value to the unsigned 0..255 range
// No ports; imported by requant_lane and concat_requant.
// -----------------------------------------------------------------------------
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif

package concat_requant_pkg;

  localparam int PICTURE_NUM = `PICTURE_NUM;

  localparam int IN_LANE_W  = 32;
  localparam int OUT_LANE_W = 8;
  localparam int PROD_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Half of one output LSB, so the following shift rounds to nearest.
  function automatic logic signed [PROD_W-1:0] round_bias(input logic [4:0] sh);
    logic signed [PROD_W-1:0] bias;
    if (sh == 5'd0) begin
      bias = 64'sd0;
    end else begin
      bias = 64'sd1 <<< (sh - 5'd1);
    end
    return bias;
  endfunction

  // Unsigned 8-bit saturation of a signed wide value.
  function automatic logic [OUT_LANE_W-1:0] clamp_u8(input logic signed [PROD_W-1:0] v);
    logic [OUT_LANE_W-1:0] res;
    if (v < 64'sd0) begin
      res = 8'd0;
    end else if (v > 64'sd255) begin
      res = 8'd255;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/concat_requant_lane.sv
// -----------------------------------------------------------------------------
// requant_lane
// One lane of the requantiser: a three-stage pipeline that turns a signed
// 32-bit accumulator value into an unsigned 8-bit activation.
//   S1: product   = data_in * scale              (64-bit signed)
//   S2: shifted   = (product + bias) >>> shift   (bias = 1<<(shift-1), or 0)
//   S3: data_out  = sat_0_255(shifted + out_zero)
// All stages advance together on en; the data path carries no reset because
// the control side qualifies every output with its own valid flag.
// Ports:
//   clk      in   clock, rising edge
//   en       in   pipeline advance enable
//   data_in  in   signed 32-bit lane input
//   scale    in   signed 32-bit multiplier (frame-constant)
//   shift    in   right-shift amount 0..31 (frame-constant)
//   out_zero in   unsigned output zero point (frame-constant)
//   data_out out  unsigned 8-bit lane result (S3 register)
// -----------------------------------------------------------------------------
module requant_lane
  import concat_requant_pkg::*;
(
  input  logic                         clk,
  input  logic                         en,
  input  logic signed [IN_LANE_W-1:0]  data_in,
  input  logic signed [IN_LANE_W-1:0]  scale,
  input  logic        [4:0]            shift,
  input  logic        [7:0]            out_zero,
  output logic        [OUT_LANE_W-1:0] data_out
);

  logic signed [PROD_W-1:0] data_ext_s;
  logic signed [PROD_W-1:0] scale_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] rounded_s;
  logic signed [PROD_W-1:0] biased_s;

  logic signed [PROD_W-1:0] prod_r;
  logic signed [PROD_W-1:0] shifted_r;
  logic        [OUT_LANE_W-1:0] out_r;

  // Combinational arithmetic feeding each pipeline register.
  always_comb begin
    // Sign-extend both operands so the 64-bit product is exact.
    data_ext_s  = $signed({{32{data_in[31]}}, data_in});
    scale_ext_s = $signed({{32{scale[31]}}, scale});
    prod_s      = data_ext_s * scale_ext_s;
    // |product| <= 2^62, so adding the bias cannot overflow 64 bits.
    rounded_s   = prod_r + round_bias(shift);
    biased_s    = shifted_r + $signed({56'd0, out_zero});
  end

  // Three-stage datapath, all stages held when en is low.
  always_ff @(posedge clk) begin
    if (en) begin
      prod_r    <= prod_s;
      shifted_r <= rounded_s >>> shift;
      out_r     <= clamp_u8(biased_s);
    end
  end

  assign data_out = out_r;

endmodule

// File: rtl/concat_requant.sv
// -----------------------------------------------------------------------------
// concat_requant
// Requantises a frame of concatenated 32-bit accumulator beats into 8-bit
// activations. Each beat carries L = PICTURE_NUM * RE_CHANNEL_IN_NUM lanes,
// each processed by its own requant_lane. A small FSM (IDLE/RUN/DRAIN)
// accepts exactly beat_total beats, tags the final one with last, and pulses
// done when that beat is taken downstream.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle frame start pulse (honoured only in IDLE)
//   beat_total in   beats in the frame, sampled on start (0 = ignored)
//   scale      in   signed requant multiplier
//   shift      in   arithmetic right shift 0..31
//   out_zero   in   unsigned output zero point
//   data_in    in   L x signed 32-bit lanes, lane k at [k*32 +: 32]
//   valid_in   in   data_in qualifier
//   ready_out  out  block accepts data_in this cycle
//   data_out   out  L x unsigned 8-bit lanes, lane k at [k*8 +: 8]
//   valid_out  out  data_out qualifier
//   ready_in   in   downstream accept
//   last_out   out  final beat of the frame (qualified by valid_out)
//   done       out  pulse on the downstream handshake of the last beat
//   busy       out  FSM not in IDLE
// -----------------------------------------------------------------------------
module concat_requant
  import concat_requant_pkg::*;
#(
  parameter int RE_CHANNEL_IN_NUM = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [15:0]                                  beat_total,
  input  logic [31:0]                                  scale,
  input  logic [4:0]                                   shift,
  input  logic [7:0]                                   out_zero,
  input  logic [PICTURE_NUM*RE_CHANNEL_IN_NUM*32-1:0]  data_in,
  input  logic                                         valid_in,
  output logic                                         ready_out,
  output logic [PICTURE_NUM*RE_CHANNEL_IN_NUM*8-1:0]   data_out,
  output logic                                         valid_out,
  input  logic                                         ready_in,
  output logic                                         last_out,
  output logic                                         done,
  output logic                                         busy
);

  localparam int L = PICTURE_NUM * RE_CHANNEL_IN_NUM;

  state_t      state_r;
  logic [15:0] count_r;
  logic [15:0] total_r;
  logic [2:0]  vld_r;   // per-stage valid, bit 2 = S3
  logic [2:0]  lst_r;   // per-stage last, travels with vld_r

  logic en_s;
  logic in_hs_s;
  logic out_hs_s;
  logic last_beat_s;
  logic done_s;

  // Handshake and advance decode.
  always_comb begin
    // The pipe moves whenever the output register is empty or being taken.
    en_s        = !vld_r[2] || ready_in;
    in_hs_s     = valid_in && (state_r == ST_RUN) && en_s;
    out_hs_s    = vld_r[2] && ready_in;
    last_beat_s = (count_r == (total_r - 16'd1));
    done_s      = out_hs_s && lst_r[2];
  end

  // Control FSM: frame length, beat counter and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= 16'd0;
      total_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (beat_total != 16'd0)) begin
            state_r <= ST_RUN;
            count_r <= 16'd0;
            total_r <= beat_total;
          end
        end
        ST_RUN: begin
          if (in_hs_s) begin
            count_r <= count_r + 16'd1;
            if (last_beat_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // A start in this cycle is deliberately dropped: we are not IDLE yet.
          if (done_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Valid/last shift register, moving in lock-step with the lane datapaths.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= 3'b000;
      lst_r <= 3'b000;
    end else if (en_s) begin
      vld_r <= {vld_r[1:0], in_hs_s};
      lst_r <= {lst_r[1:0], in_hs_s && last_beat_s};
    end
  end

  assign ready_out = (state_r == ST_RUN) && en_s;
  assign valid_out = vld_r[2];
  assign last_out  = lst_r[2];
  assign done      = done_s;
  assign busy      = (state_r != ST_IDLE);

  // One independent requant pipeline per lane.
  for (genvar k = 0; k < L; k++) begin : g_lane
    requant_lane u_lane (
      .clk      (clk),
      .en       (en_s),
      .data_in  (data_in[k*32 +: 32]),
      .scale    (scale),
      .shift    (shift),
      .out_zero (out_zero),
      .data_out (data_out[k*8 +: 8])
    );
  end

endmodule

// File: tb/tb_concat_requant.sv
// -----------------------------------------------------------------------------
// tb_concat_requant
// Self-checking bench for concat_requant: a table of single-beat requant
// vectors, directed multi-cycle sequences (latency, stall, ignored starts,
// mid-frame reset) and randomised frames, all scored against a plain
// arithmetic model of the requant rule.
// -----------------------------------------------------------------------------
module tb_concat_requant;
  import concat_requant_pkg::*;

  localparam int CH = 16;
  localparam int L  = PICTURE_NUM * CH;
  localparam int OW = L * 8;
  localparam int IW = L * 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   beat_total = 16'd0;
  logic [31:0]   scale = 32'd0;
  logic [4:0]    shift = 5'd0;
  logic [7:0]    out_zero = 8'd0;
  logic [IW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [OW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b1;
  logic          last_out;
  logic          done;
  logic          busy;

  concat_requant #(.RE_CHANNEL_IN_NUM(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .beat_total(beat_total),
    .scale(scale), .shift(shift), .out_zero(out_zero),
    .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .last_out(last_out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: exact integer requant of one lane.
  function automatic int ref_lane(input logic signed [31:0] x, input logic signed [31:0] sc,
                                  input int sh, input int oz);
    longint p;
    p = longint'(x) * longint'(sc);
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    p = p + oz;
    if (p < 0) return 0;
    if (p > 255) return 255;
    return int'(p);
  endfunction

  function automatic logic [OW-1:0] ref_beat(input logic [IW-1:0] d, input logic [31:0] sc,
                                             input logic [4:0] sh, input logic [7:0] oz);
    logic [OW-1:0] r;
    logic signed [31:0] x;
    int v;
    r = '0;
    for (int k = 0; k < L; k++) begin
      x = d[k*32 +: 32];
      v = ref_lane(x, sc, int'(sh), int'(oz));
      r[k*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_m;
  bit            mon_on = 1'b0;
  int            hs_count = 0;
  int            frame_len = 0;
  int            first_hs = -1;
  int            vo_rel[$];
  int            done_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [OW-1:0] last_vec = '0;
  logic          exp_done_m;

  // Monitor: scoreboard push on input handshake, pop/compare on output handshake.
  always @(negedge clk) begin
    if (mon_on) begin
      exp_done_m = 1'b0;
      if (prev_stall) begin
        chki("hold_valid", int'(valid_out), 1);
        chk("hold_data", data_out, prev_data);
        chki("hold_last", int'(last_out), int'(prev_last));
      end
      if (valid_out && !ready_in) chki("stall_ready_out", int'(ready_out), 0);
      if (valid_in && ready_out) begin
        e_m.data = ref_beat(data_in, scale, shift, out_zero);
        e_m.last = (hs_count == frame_len - 1);
        sb.push_back(e_m);
        hs_count++;
        if (first_hs < 0) first_hs = cyc;
      end
      if (valid_out && first_hs >= 0) vo_rel.push_back(cyc - first_hs);
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", data_out);
        end else begin
          e_m = sb.pop_front();
          chk("data_out", data_out, e_m.data);
          chki("last_out", int'(last_out), int'(e_m.last));
          exp_done_m = e_m.last;
          last_vec = data_out;
        end
      end
      chki("done", int'(done), int'(exp_done_m));
      if (done) done_cnt++;
      prev_stall = valid_out && !ready_in;
      prev_data  = data_out;
      prev_last  = last_out;
    end
  end

  function automatic logic [IW-1:0] gen_data(input int dmode);
    logic [IW-1:0] d;
    logic [31:0] c [5];
    c[0] = 32'h0000_0000; c[1] = 32'h7FFF_FFFF; c[2] = 32'h8000_0000;
    c[3] = 32'hFFFF_FFFF; c[4] = 32'h0000_0001;
    for (int k = 0; k < L; k++) begin
      case (dmode)
        0:       d[k*32 +: 32] = $urandom;
        1:       d[k*32 +: 32] = 32'($urandom_range(0, 65535)) - 32'd32768;
        default: d[k*32 +: 32] = c[$urandom_range(0, 4)];
      endcase
    end
    return d;
  endfunction

  function automatic logic rdy(input int rmode, input int step);
    logic [3:0] pat;
    pat = 4'b1001;  // ready sequence 1,0,0,1 read from bit 3 down
    case (rmode)
      0:       return 1'b1;
      1:       return pat[3 - (step % 4)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Drive one frame; optionally inject a start while running or abort by reset.
  task automatic run_frame(input int n, input logic [31:0] sc, input logic [4:0] sh,
                           input logic [7:0] oz, input int rmode, input int dmode,
                           input int inj_at, input int abort_at,
                           input logic [31:0] lane0, input bit use_lane0);
    int sent, guard, step;
    @(posedge clk); #1;
    scale = sc; shift = sh; out_zero = oz; beat_total = 16'(n);
    start = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    frame_len = n; hs_count = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; guard = 0; step = 0;
    while (sent < n && guard < 1000) begin
      valid_in = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_in = gen_data(dmode);
      if (use_lane0) data_in[31:0] = lane0;
      ready_in = rdy(rmode, step);
      if (inj_at == sent) begin
        start = 1'b1; beat_total = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (valid_in && ready_out) sent++;
      @(posedge clk); #1;
      guard++; step++;
      if (abort_at > 0 && sent == abort_at) begin
        rst = 1'b1; valid_in = 1'b0; start = 1'b0; ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chki("abort_ready_out", int'(ready_out), 0);
        chki("abort_valid_out", int'(valid_out), 0);
        chki("abort_last_out", int'(last_out), 0);
        chki("abort_done", int'(done), 0);
        chki("abort_busy", int'(busy), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chki("abort_no_done", done_cnt, 0);
        return;
      end
    end
    start = 1'b0; valid_in = 1'b0;
    while (done_cnt == 0 && guard < 1000) begin
      ready_in = rdy(rmode, step);
      @(posedge clk); #1;
      guard++; step++;
    end
    ready_in = 1'b1;
    if (guard >= 1000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=%0d beats expected=%0d", sent, n);
    end
    @(negedge clk);
    chki("frame_done_once", done_cnt, 1);
    chki("frame_idle_busy", int'(busy), 0);
    chki("frame_sb_empty", sb.size(), 0);
  endtask

  typedef struct {
    logic [31:0] lane;
    logic [31:0] sc;
    logic [4:0]  sh;
    logic [7:0]  oz;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'sd1000,     32'sd3, 5'd4,  8'd10,  8'd198};
    tbl[1] = '{-32'sd5000,    32'sd3, 5'd4,  8'd10,  8'd0};
    tbl[2] = '{32'sd2000000,  32'sd3, 5'd4,  8'd10,  8'd255};
    tbl[3] = '{32'sd24,       32'sd1, 5'd4,  8'd0,   8'd2};
    tbl[4] = '{32'sd23,       32'sd1, 5'd4,  8'd0,   8'd1};
    tbl[5] = '{-32'sd24,      32'sd1, 5'd4,  8'd128, 8'd127};
    tbl[6] = '{32'sd7,        32'sd1, 5'd0,  8'd0,   8'd7};
    tbl[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd31, 8'd0, 8'd255};
    tbl[8] = '{-32'sd3,       32'sd1, 5'd1,  8'd100, 8'd99};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chki("rst_ready_out", int'(ready_out), 0);
    chki("rst_valid_out", int'(valid_out), 0);
    chki("rst_last_out", int'(last_out), 0);
    chki("rst_done", int'(done), 0);
    chki("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // Table-driven single-beat vectors; lane 0 carries the table value.
    for (int i = 0; i < 9; i++) begin
      run_frame(1, tbl[i].sc, tbl[i].sh, tbl[i].oz, 0, 1, -1, 0, tbl[i].lane, 1'b1);
      chki($sformatf("tbl%0d_lane0", i), int'(last_vec[7:0]), int'(tbl[i].exp));
    end

    // 4-beat frame, continuous flow: valid_out on cycles 3..6 after first handshake.
    vo_rel.delete();
    first_hs = -1;
    run_frame(4, 32'sd37, 5'd6, 8'd128, 0, 1, -1, 0, 32'd0, 1'b0);
    chki("lat_count", vo_rel.size(), 4);
    for (int i = 0; i < 4 && i < vo_rel.size(); i++)
      chki($sformatf("lat_beat%0d", i), vo_rel[i], 3 + i);

    // 6-beat frame with ready 1,0,0,1 back-pressure.
    run_frame(6, 32'sd211, 5'd9, 8'd64, 1, 1, -1, 0, 32'd0, 1'b0);

    // start pulsed while running is ignored (frame keeps its 5 beats).
    run_frame(5, 32'sd5, 5'd3, 8'd20, 0, 1, 2, 0, 32'd0, 1'b0);

    // start with beat_total = 0 does nothing.
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; beat_total = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chki("zero_start_busy", int'(busy), 0);
    end
    chki("zero_start_no_done", done_cnt, 0);

    // Reset at beat 3 of 8, then a normal 2-beat frame.
    run_frame(8, 32'sd77, 5'd7, 8'd30, 0, 1, -1, 3, 32'd0, 1'b0);
    run_frame(2, 32'sd13, 5'd2, 8'd5, 0, 1, -1, 0, 32'd0, 1'b0);

    // Randomised frames with random back-pressure and valid gaps.
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(1, 12),
                (f % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023)) - 32'd512,
                5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                2, f % 3, -1, 0, 32'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/concat_requant.md
CONCAT_REQUANT -- requirements
Module: concat_requant

Interface
REQ-001 Parameter RE_CHANNEL_IN_NUM, default 16, is the number of channels per beat; lane count L = `PICTURE_NUM*RE_CHANNEL_IN_NUM, with `PICTURE_NUM taken from the shared Para.v header.
REQ-002 clk  input  1  is the single clock, and all logic SHALL be rising-edge.
REQ-003 rst  input  1  is the reset; reset is synchronous and active-high.
REQ-004 start  input  1  is a one-cycle pulse that begins a frame.
REQ-005 beat_total  input  16  is the number of beats in the frame, sampled on start.
REQ-006 scale  input  32  is the signed requant multiplier, held stable for the whole frame.
REQ-007 shift  input  5  is the right-shift amount, 0..31.
REQ-008 out_zero  input  8  is the unsigned output zero point.
REQ-009 data_in  input  L*32  carries signed 32-bit lanes (the zero-added concat data); lane k occupies bits [(k+1)*32-1 : k*32].
REQ-010 valid_in  input  1  qualifies data_in.
REQ-011 ready_out  output  1  means the block accepts data_in this cycle.
REQ-012 data_out  output  L*8  carries unsigned 8-bit lanes, with lane k at [(k+1)*8-1 : k*8].
REQ-013 valid_out  output  1  qualifies data_out.
REQ-014 ready_in  input  1  is the downstream accept signal.
REQ-015 last_out  output  1  marks the final beat of the frame and is qualified by valid_out.
REQ-016 done  output  1  is a one-cycle pulse issued when the last beat has been accepted downstream.
REQ-017 busy  output  1  is high whenever the state is not IDLE.

Function
REQ-018 The block SHALL use the FSM states IDLE, RUN and DRAIN.
- IDLE->RUN on start with beat_total != 0.
- RUN->DRAIN when the beat with count == beat_total-1 is accepted.
- DRAIN->IDLE on the downstream handshake of the last_out beat.
REQ-019 start SHALL be ignored in RUN and DRAIN, and SHALL be ignored in IDLE when beat_total == 0 (no done is issued).
REQ-020 Advance enable is en = !valid_s3 || ready_in. ready_out = (state==RUN) && en, and the input handshake is valid_in && ready_out.
REQ-021 The pipeline SHALL have 3 stages, all advancing on en.
- S1 computes the 64-bit signed product data_in_k * scale.
- S2 adds rounding, (1<<(shift-1)) when shift > 0 and 0 otherwise, then performs an arithmetic right shift by shift.
- S3 adds out_zero and saturates to the range 0..255.
REQ-022 With ready_in held high, latency from input handshake to valid_out SHALL be exactly 3 cycles, at a throughput of 1 beat per cycle.
REQ-023 While ready_in is low with valid_out high, data_out, valid_out and last_out SHALL hold, and no beat may be lost or duplicated.
REQ-024 The per-stage valid and last flags SHALL travel with the data, and last is set on the accepted beat where count == beat_total-1.
REQ-025 The beat counter SHALL be 16 bits, cleared on start and incremented on each input handshake; it never wraps within a frame because acceptance stops in DRAIN.
REQ-026 done SHALL pulse in the same cycle as the valid_out && ready_in && last_out handshake, and the state is IDLE the following cycle.
REQ-027 A start arriving in that same cycle is ignored, because the state is still DRAIN.
REQ-028 Lanes SHALL be processed identically and independently, with no cross-lane arithmetic.

Reset
REQ-029 On rst, the state SHALL go to IDLE, the counter to 0, and all stage valid and last flags to 0.
REQ-030 After rst, ready_out, valid_out, last_out, done and busy SHALL all be 0.
REQ-031 data_out need not be reset but SHALL NOT be observed while valid_out = 0.
REQ-032 rst asserted mid-frame SHALL discard all in-flight beats, and done SHALL NOT fire for the aborted frame.

Structure
REQ-033 `PICTURE_NUM and the FSM state encodings SHALL reside in the shared Para.v header.
REQ-034 The per-lane multiply/round/shift/clamp datapath SHALL be one sub-module, requant_lane, instantiated L times by generate.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Lane=1000, scale=3, shift=4, out_zero=10: result 198. Lane=-5000, same settings: result 0. Lane=2000000, same settings: result 255.
- Rounding: lane=24, scale=1, shift=4 -> 2, and lane=23 -> 1. Lane=-24, scale=1, shift=4, out_zero=128 -> 127. shift=0, lane=7, out_zero=0 -> 7.
- beat_total=4 with continuous valid and ready: valid_out is high on cycles 3..6 after the first handshake, last_out is high only on the 4th beat, and done pulses once.
- Toggle ready_in 1,0,0,1 over a 6-beat frame: the output sequence is unchanged and gapless in order, and ready_out drops while stalled.
- start issued in RUN is ignored; start with beat_total=0 leaves busy=0 and no done.
- Assert rst at beat 3 of 8: outputs are 0 on the next cycle, no done follows, and a new 2-beat frame then completes normally.
